// File: rtl/fetch_sequencer.sv
// Stall-aware fetch stage: walks a snapshot of the packed program, one word per handshake.
// Optional FETCH_SEQ_LOOP_EN wraps to word 0 instead of terminating.
module fetch_sequencer #(
    parameter int WORD_W = 32,
    parameter int DEPTH  = 10,
    parameter int PC_W   = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    abort,
    input  logic [DEPTH*WORD_W-1:0] program_addr_array,
    output logic [WORD_W-1:0]       instr,
    output logic                    instr_valid,
    input  logic                    instr_ready,
    output logic [PC_W-1:0]         pc,
    output logic                    busy,
    output logic                    done,
    output logic [7:0]              issued_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        ISSUE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [PC_W-1:0] LAST_PC = PC_W'(DEPTH - 1);

    state_t                    state_q, state_d;
    logic [DEPTH*WORD_W-1:0]   snap_q, snap_d;
    logic [WORD_W-1:0]         instr_q, instr_d;
    logic                      valid_q, valid_d;
    logic [PC_W-1:0]           pc_q, pc_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;
    logic [7:0]                cnt_q, cnt_d;
    logic [WORD_W-1:0]         cur_word;

    always_comb begin
        cur_word = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (pc_q == PC_W'(k)) begin
                cur_word = snap_q[k*WORD_W +: WORD_W];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        snap_d  = snap_q;
        instr_d = instr_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    snap_d  = program_addr_array;
                    pc_d    = '0;
                    cnt_d   = '0;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                if (cur_word == '0) begin
`ifdef FETCH_SEQ_LOOP_EN
                    if (pc_q != '0) begin
                        pc_d    = '0;
                        state_d = FETCH;
                    end else begin
                        state_d = DONE;
                    end
`else
                    state_d = DONE;
`endif
                end else begin
                    instr_d = cur_word;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (instr_ready) begin
                    if (cnt_q != 8'hFF) begin
                        cnt_d = cnt_q + 8'd1;
                    end
                    if (pc_q == LAST_PC) begin
`ifdef FETCH_SEQ_LOOP_EN
                        pc_d    = '0;
                        state_d = FETCH;
`else
                        state_d = DONE;
`endif
                    end else begin
                        pc_d    = pc_q + 1'b1;
                        state_d = FETCH;
                    end
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Abort discards everything decided above, including a same-cycle handshake.
        if (abort) begin
            state_d = IDLE;
            snap_d  = snap_q;
            instr_d = instr_q;
            pc_d    = pc_q;
            cnt_d   = cnt_q;
        end
        valid_d = (state_d == ISSUE);
        busy_d  = (state_d == FETCH) || (state_d == ISSUE);
        done_d  = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            snap_q  <= '0;
            instr_q <= '0;
            valid_q <= 1'b0;
            pc_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            snap_q  <= snap_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
            pc_q    <= pc_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
        end
    end

    assign instr       = instr_q;
    assign instr_valid = valid_q;
    assign pc          = pc_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign issued_cnt  = cnt_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed-vector bench for fetch_sequencer; define FETCH_SEQ_LOOP_EN
// to run the wrap-mode vectors instead of the terminating ones.
module tb_fetch_sequencer;

    localparam int WORD_W = 32;
    localparam int DEPTH  = 10;
    localparam int PC_W   = 4;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic                    start;
    logic                    abort;
    logic [DEPTH*WORD_W-1:0] prog_flat;
    logic [WORD_W-1:0]       instr;
    logic                    instr_valid;
    logic                    instr_ready;
    logic [PC_W-1:0]         pc;
    logic                    busy;
    logic                    done;
    logic [7:0]              issued_cnt;

    logic [WORD_W-1:0] prog [DEPTH];
    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fetch_sequencer #(.WORD_W(WORD_W), .DEPTH(DEPTH), .PC_W(PC_W)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .abort(abort),
        .program_addr_array(prog_flat),
        .instr(instr),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .pc(pc),
        .busy(busy),
        .done(done),
        .issued_cnt(issued_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic load();
        for (int k = 0; k < DEPTH; k++) begin
            prog_flat[k*WORD_W +: WORD_W] = prog[k];
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic kick();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        instr_ready = 1'b0;
        prog_flat = '0;
        for (int k = 0; k < DEPTH; k++) prog[k] = '0;
        tick();
        tick();
        chk("rst_valid", instr_valid, 0);
        chk("rst_instr", instr, 0);
        chk("rst_pc", pc, 0);
        chk("rst_cnt", issued_cnt, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        rst_n = 1'b1;
        tick();

`ifdef FETCH_SEQ_LOOP_EN
        prog[0] = 32'h5;
        prog[1] = 32'h6;
        load();
        instr_ready = 1'b1;
        kick();
        for (int r = 0; r < 3; r++) begin
            tick();
            chk("loop_i0", instr, 32'h5);
            chk("loop_v0", instr_valid, 1);
            chk("loop_d", done, 0);
            tick();
            tick();
            chk("loop_i1", instr, 32'h6);
            chk("loop_p1", pc, 1);
            tick();
            chk("loop_p2", pc, 2);
            chk("loop_d", done, 0);
            tick();
            chk("loop_wrap", pc, 0);
            chk("loop_busy", busy, 1);
            chk("loop_cnt", issued_cnt, 2 * (r + 1));
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("loop_abort_busy", busy, 0);
        prog[0] = 32'h0;
        load();
        kick();
        tick();
        chk("loop_empty_done", done, 1);
        chk("loop_empty_cnt", issued_cnt, 0);
        tick();
        chk("loop_empty_end", done, 0);
`else
        // zero-word termination after three words
        prog[0] = 32'h11;
        prog[1] = 32'h22;
        prog[2] = 32'h33;
        load();
        instr_ready = 1'b1;
        kick();
        chk("t1_fetch_busy", busy, 1);
        chk("t1_fetch_valid", instr_valid, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t1_valid", instr_valid, 1);
            chk("t1_instr", instr, 32'h11 * (i + 1));
            chk("t1_pc", pc, i);
            tick();
            chk("t1_gap", instr_valid, 0);
            chk("t1_cnt", issued_cnt, i + 1);
        end
        tick();
        chk("t1_done", done, 1);
        chk("t1_cnt_fin", issued_cnt, 3);
        chk("t1_pc_fin", pc, 3);
        chk("t1_busy_fin", busy, 0);
        chk("t1_instr_fin", instr, 32'h33);
        tick();
        chk("t1_done_end", done, 0);

        // full array with a five-cycle stall on word 4
        for (int k = 0; k < DEPTH; k++) prog[k] = 32'hA0 + k;
        load();
        kick();
        for (int k = 0; k < DEPTH; k++) begin
            instr_ready = (k != 4);
            tick();
            chk("t2_instr", instr, 32'hA0 + k);
            chk("t2_pc", pc, k);
            if (k == 4) begin
                for (int s = 0; s < 5; s++) begin
                    tick();
                    chk("t2_hold_v", instr_valid, 1);
                    chk("t2_hold_i", instr, 32'hA4);
                    chk("t2_hold_pc", pc, 4);
                end
                chk("t2_hold_cnt", issued_cnt, 4);
            end
            instr_ready = 1'b1;
            tick();
            if (k < DEPTH - 1) chk("t2_cnt", issued_cnt, k + 1);
        end
        chk("t2_done", done, 1);
        chk("t2_cnt_fin", issued_cnt, 10);
        chk("t2_pc_fin", pc, 9);
        tick();

        // async reset while stalled on word 3
        kick();
        for (int k = 0; k < 3; k++) begin
            tick();
            tick();
        end
        instr_ready = 1'b0;
        tick();
        chk("t3_pre_pc", pc, 3);
        chk("t3_pre_v", instr_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("t3_valid", instr_valid, 0);
        chk("t3_pc", pc, 0);
        chk("t3_cnt", issued_cnt, 0);
        chk("t3_busy", busy, 0);
        chk("t3_instr", instr, 0);
        tick();
        rst_n = 1'b1;
        tick();

        // empty program
        for (int k = 0; k < DEPTH; k++) prog[k] = '0;
        load();
        kick();
        tick();
        chk("t4_done", done, 1);
        chk("t4_cnt", issued_cnt, 0);
        tick();
        chk("t4_done_end", done, 0);

        // start while in ISSUE and while in DONE
        prog[0] = 32'h11;
        prog[1] = 32'h22;
        load();
        kick();
        instr_ready = 1'b0;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t5_pc", pc, 0);
        chk("t5_instr", instr, 32'h11);
        chk("t5_valid", instr_valid, 1);
        instr_ready = 1'b1;
        tick();
        tick();
        chk("t5_instr2", instr, 32'h22);
        tick();
        tick();
        chk("t5_done", done, 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t5_idle_busy", busy, 0);
        chk("t5_idle_pc", pc, 2);
        chk("t5_idle_cnt", issued_cnt, 2);

        // abort with handshake on word 2, array edited mid-run
        for (int k = 0; k < DEPTH; k++) prog[k] = 32'hC0 + k;
        load();
        kick();
        prog_flat = '1;
        for (int k = 0; k < 2; k++) begin
            tick();
            chk("t6_instr", instr, 32'hC0 + k);
            tick();
        end
        tick();
        chk("t6_instr2", instr, 32'hC2);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t6_valid", instr_valid, 0);
        chk("t6_busy", busy, 0);
        chk("t6_cnt", issued_cnt, 2);
        chk("t6_pc", pc, 2);
        chk("t6_done", done, 0);
        tick();
        chk("t6_done2", done, 0);

        // abort beats start in IDLE
        abort = 1'b1;
        start = 1'b1;
        tick();
        abort = 1'b0;
        start = 1'b0;
        chk("t7_busy", busy, 0);
        chk("t7_cnt", issued_cnt, 2);
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
